// File: rtl/real_corr_accumulator.sv
// Real correlation accumulator: sums R = yr*yr^T + yi*yi^T over ACC_LEN valid samples.
// Define CORR_MEAN_EN to output window means ((acc+term) >>> LOG2_ACC) instead of raw sums.
module real_corr_accumulator #(
   parameter int DIN_WIDTH = 19,
   parameter int ACC_LEN   = 1024,
   localparam int LOG2_ACC = $clog2(ACC_LEN),
   localparam int ACC_W    = 2*DIN_WIDTH+1+LOG2_ACC
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic signed [DIN_WIDTH-1:0] y1_re,
   input  logic signed [DIN_WIDTH-1:0] y1_im,
   input  logic signed [DIN_WIDTH-1:0] y2_re,
   input  logic signed [DIN_WIDTH-1:0] y2_im,
   input  logic                        din_valid,
   input  logic                        acc_clear,
   output logic signed [ACC_W-1:0]     r11,
   output logic signed [ACC_W-1:0]     r22,
   output logic signed [ACC_W-1:0]     r12,
   output logic                        dout_valid
);

   localparam int P_W    = 2*DIN_WIDTH;
   localparam int TERM_W = 2*DIN_WIDTH+1;
   localparam logic [LOG2_ACC-1:0] CNT_LAST = LOG2_ACC'(ACC_LEN-1);

   function automatic logic signed [P_W-1:0] smul(input logic signed [DIN_WIDTH-1:0] a,
                                                  input logic signed [DIN_WIDTH-1:0] b);
      return P_W'(a) * P_W'(b);
   endfunction

   logic [LOG2_ACC-1:0]         cnt;
   logic signed [DIN_WIDTH-1:0] s1_y1r, s1_y1i, s1_y2r, s1_y2i;
   logic                        s1_v, s1_last;
   logic signed [P_W-1:0]       p11r, p11i, p22r, p22i, p12r, p12i;
   logic                        s2_v, s2_last;
   logic signed [TERM_W-1:0]    t11, t22, t12;
   logic                        s3_v, s3_last;
   logic signed [ACC_W-1:0]     acc11, acc22, acc12;
   logic signed [ACC_W-1:0]     sum11, sum22, sum12;
   logic signed [ACC_W-1:0]     out11, out22, out12;

   // S1: input capture, sample counting and last tagging
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         s1_v    <= 1'b0;
         s1_last <= 1'b0;
         s1_y1r  <= '0;
         s1_y1i  <= '0;
         s1_y2r  <= '0;
         s1_y2i  <= '0;
      end else begin
         s1_y1r <= y1_re;
         s1_y1i <= y1_im;
         s1_y2r <= y2_re;
         s1_y2i <= y2_im;
         if (acc_clear) begin
            cnt     <= '0;
            s1_v    <= 1'b0;
            s1_last <= 1'b0;
         end else begin
            s1_v    <= din_valid;
            s1_last <= din_valid && (cnt == CNT_LAST);
            if (din_valid)
               cnt <= cnt + LOG2_ACC'(1);
         end
      end
   end

   // S2: products
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p11r    <= '0;
         p11i    <= '0;
         p22r    <= '0;
         p22i    <= '0;
         p12r    <= '0;
         p12i    <= '0;
         s2_v    <= 1'b0;
         s2_last <= 1'b0;
      end else begin
         p11r    <= smul(s1_y1r, s1_y1r);
         p11i    <= smul(s1_y1i, s1_y1i);
         p22r    <= smul(s1_y2r, s1_y2r);
         p22i    <= smul(s1_y2i, s1_y2i);
         p12r    <= smul(s1_y1r, s1_y2r);
         p12i    <= smul(s1_y1i, s1_y2i);
         s2_v    <= s1_v && !acc_clear;
         s2_last <= s1_last;
      end
   end

   // S3: term sums
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t11     <= '0;
         t22     <= '0;
         t12     <= '0;
         s3_v    <= 1'b0;
         s3_last <= 1'b0;
      end else begin
         t11     <= TERM_W'(p11r) + TERM_W'(p11i);
         t22     <= TERM_W'(p22r) + TERM_W'(p22i);
         t12     <= TERM_W'(p12r) + TERM_W'(p12i);
         s3_v    <= s2_v && !acc_clear;
         s3_last <= s2_last;
      end
   end

   always_comb begin
      sum11 = acc11 + ACC_W'(t11);
      sum22 = acc22 + ACC_W'(t22);
      sum12 = acc12 + ACC_W'(t12);
`ifdef CORR_MEAN_EN
      out11 = sum11 >>> LOG2_ACC;
      out22 = sum22 >>> LOG2_ACC;
      out12 = sum12 >>> LOG2_ACC;
`else
      out11 = sum11;
      out22 = sum22;
      out12 = sum12;
`endif
   end

   // S4: the closing sample publishes and restarts the accumulators in the same edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc11      <= '0;
         acc22      <= '0;
         acc12      <= '0;
         r11        <= '0;
         r22        <= '0;
         r12        <= '0;
         dout_valid <= 1'b0;
      end else if (acc_clear) begin
         acc11      <= '0;
         acc22      <= '0;
         acc12      <= '0;
         dout_valid <= 1'b0;
      end else begin
         dout_valid <= s3_v && s3_last;
         if (s3_v) begin
            if (s3_last) begin
               r11   <= out11;
               r22   <= out22;
               r12   <= out12;
               acc11 <= '0;
               acc22 <= '0;
               acc12 <= '0;
            end else begin
               acc11 <= sum11;
               acc22 <= sum22;
               acc12 <= sum12;
            end
         end
      end
   end

endmodule
